load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the execute stage and the data ports of the unified memory. Accepts load/store requests through a valid/ready handshake. Stores are buffered in an in-order store queue that drains to the memory write port under its `write_activate`/`write_done` handshake. Loads are issued only once the queue has drained, and their results are sign- or zero-extended. This gives strict program order between stores and later loads, with no forwarding.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, data width; `DATA_BYTE_SIZE = DATA_WIDTH/8`; `DATA_INDEXING_WIDTH = $clog2(DATA_BYTE_SIZE)`.
- `STORE_QUEUE_DEPTH`, 4, store queue entries; power of two, at least 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted at this posedge if `req_valid`.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 byte, 1 half, 2 word, 3 treated as word.
- `req_signed` in 1: load sign-extends when set; ignored for stores.
- `req_addr` in `ADDR_WIDTH`: byte address; any alignment is legal.
- `req_wdata` in `DATA_WIDTH`: store data, low bytes used.
- `load_valid` out 1: one-cycle pulse, `load_data` valid.
- `load_data` out `DATA_WIDTH`: extended load result, held until the next load completes.
- `store_queue_empty` out 1: no pending stores.
- `mem_fetch_addr` out `ADDR_WIDTH`: memory data fetch address.
- `mem_fetched_data` in `DATA_WIDTH`: memory fetch data (combinational from address).
- `mem_fetch_done` in 1: fetch data valid this cycle.
- `mem_write_addr` out `ADDR_WIDTH`: write address.
- `mem_write_data` out `DATA_WIDTH`: write data.
- `mem_bytes_to_write` out `DATA_INDEXING_WIDTH+1`: byte count (1, 2, 4).
- `mem_write_activate` out 1: write requested.
- `mem_write_done` in 1: write commits at the coming posedge.

## Operation
- **State machine:** `IDLE`, `LOAD`.
- **`req_ready`:**
  - `IDLE` and store: `req_ready = !full`.
  - `IDLE` and load: `req_ready = store_queue_empty`.
  - `LOAD`: `req_ready = 0`.
  - `req_ready` depends on `req_is_store`. Upstream holds all `req_*` stable while `req_valid` is high and not accepted.
- **Store queue:**
  - Circular FIFO with head/tail pointers wrapping modulo `STORE_QUEUE_DEPTH`, plus a count of width `$clog2(STORE_QUEUE_DEPTH)+1`.
  - Push stores `{addr, wdata, bytes}`, where `bytes = 1 << min(size, 2)`.
- **Drain:**
  - `mem_write_activate = !store_queue_empty`.
  - `mem_write_addr`, `mem_write_data` and `mem_bytes_to_write` come from the head entry and stay stable until popped.
  - Pop the head at the posedge where `mem_write_done` is 1.
- **Simultaneous push and pop:** count is unchanged. Full and empty are evaluated from registered count only. A pop while full does not raise `req_ready` in the same cycle.
- **Load accept (`IDLE`):** register address, size and signed into the load registers; go to `LOAD`.
- **`LOAD` state:**
  - `mem_fetch_addr` = registered address.
  - At the posedge with `mem_fetch_done` = 1: capture the extended data into `load_data`, set `load_valid` for the following cycle, return to `IDLE`.
- **Extension:**
  - Byte: `data[7:0]`, sign-extended if signed, else zero-extended.
  - Half: `data[15:0]`, same rule.
  - Word: `data` unchanged.
- **Outside `LOAD`:** `mem_fetch_addr` holds the last load address.
- **Reset values:**
  - Queue empty, `IDLE`.
  - `store_queue_empty` = 1; `mem_write_activate` = 0.
  - `load_valid` = 0; `load_data` = 0; `mem_fetch_addr` = 0.
  - Write address/data/bytes = 0.
- **Reset mid-operation:** pending stores are discarded, an in-flight load is abandoned with no `load_valid`, and `req_ready` is re-evaluated from the reset state.

## Timing
- **Store:** accepted at edge N; `mem_write_activate` is high in cycle N+1. Commit requires `mem_write_done`, which the memory grants on alternate cycles, so sustained drain rate is ≤ 1 store per 2 cycles.
- **Load, empty queue:** accepted at edge N; fetch address driven in cycle N+1. With `mem_fetch_done` = 1, data is captured at edge N+1 and `load_valid` is high in cycle N+2. Each cycle `mem_fetch_done` is low adds one cycle.
- **Back-to-back loads:** minimum 2 cycles per load. The next load can be accepted in the cycle `load_valid` is high.
- **Load behind stores:** stalls until the edge that pops the last store, then behaves as the empty-queue case.

## Test plan
- **Reset:** hold `rst` 2 cycles. Then `store_queue_empty`=1, `mem_write_activate`=0, `load_valid`=0, `load_data`=0. `req_ready`=1 for both a store and a load request.
- **Word store:** store word `0xDEADBEEF` to `0x10`. Next cycle: `mem_write_activate`=1, `mem_write_addr`=0x10, `mem_bytes_to_write`=4, held until `mem_write_done`. Queue is empty the cycle after commit.
- **Queue full:** hold `mem_write_done`=0 and issue 5 back-to-back stores (depth 4). Four are accepted and `req_ready`=0 for the 5th. Release `mem_write_done`: the 5th is accepted the cycle after the first pop, and entries commit in order.
- **Store then signed byte load:** store byte `0x80` to `0x20`, then a signed byte load from `0x20`. The load stalls until the queue is empty, then `load_data`=`0xFFFFFF80`. The same load unsigned gives `0x00000080`.
- **Fetch stall:** signed half load with memory returning `0x00008001` and `mem_fetch_done` low for 3 cycles. `load_valid` arrives 3 cycles later than nominal, `load_data`=`0xFFFF8001`, and `req_ready`=0 throughout.
- **Reset mid-drain:** 3 stores queued, then `rst` pulsed. The cycle after reset `mem_write_activate`=0 and `store_queue_empty`=1, with no further writes.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: in-order store queue draining to the memory write port,
// loads issued only once the queue is empty, with sign/zero extension.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH          = 32,
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned STORE_QUEUE_DEPTH   = 4,
  localparam int unsigned DATA_BYTE_SIZE      = DATA_WIDTH / 8,
  localparam int unsigned DATA_INDEXING_WIDTH = $clog2(DATA_BYTE_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_is_store,
  input  logic [1:0]                   req_size,
  input  logic                         req_signed,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         load_valid,
  output logic [DATA_WIDTH-1:0]        load_data,
  output logic                         store_queue_empty,
  output logic [ADDR_WIDTH-1:0]        mem_fetch_addr,
  input  logic [DATA_WIDTH-1:0]        mem_fetched_data,
  input  logic                         mem_fetch_done,
  output logic [ADDR_WIDTH-1:0]        mem_write_addr,
  output logic [DATA_WIDTH-1:0]        mem_write_data,
  output logic [DATA_INDEXING_WIDTH:0] mem_bytes_to_write,
  output logic                         mem_write_activate,
  input  logic                         mem_write_done
);

  localparam int unsigned PTR_W   = $clog2(STORE_QUEUE_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned BYTES_W = DATA_INDEXING_WIDTH + 1;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ADDR_WIDTH-1:0] sq_addr_q  [STORE_QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] sq_addr_d  [STORE_QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] sq_data_q  [STORE_QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] sq_data_d  [STORE_QUEUE_DEPTH];
  logic [BYTES_W-1:0]    sq_bytes_q [STORE_QUEUE_DEPTH];
  logic [BYTES_W-1:0]    sq_bytes_d [STORE_QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] ld_addr_q, ld_addr_d;
  logic [1:0]            ld_size_q, ld_size_d;
  logic                  ld_signed_q, ld_signed_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  load_valid_q, load_valid_d;

  logic                  full, push, pop;
  logic [1:0]            eff_size;
  logic [DATA_WIDTH-1:0] ext_data;

  // Full/empty come from the registered count only.
  assign full               = (count_q == CNT_W'(STORE_QUEUE_DEPTH));
  assign store_queue_empty  = (count_q == '0);
  assign mem_write_activate = !store_queue_empty;
  assign mem_write_addr     = sq_addr_q[head_q];
  assign mem_write_data     = sq_data_q[head_q];
  assign mem_bytes_to_write = sq_bytes_q[head_q];
  assign mem_fetch_addr     = ld_addr_q;
  assign load_data          = load_data_q;
  assign load_valid         = load_valid_q;
  assign eff_size           = (req_size == 2'd3) ? 2'd2 : req_size;

  // Extend the fetched word according to the registered load size.
  always_comb begin
    ext_data = mem_fetched_data;
    case (ld_size_q)
      2'd0: ext_data = {{(DATA_WIDTH-8){ld_signed_q & mem_fetched_data[7]}},
                        mem_fetched_data[7:0]};
      2'd1: ext_data = {{(DATA_WIDTH-16){ld_signed_q & mem_fetched_data[15]}},
                        mem_fetched_data[15:0]};
      default: ext_data = mem_fetched_data;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    sq_addr_d    = sq_addr_q;
    sq_data_d    = sq_data_q;
    sq_bytes_d   = sq_bytes_q;
    ld_addr_d    = ld_addr_q;
    ld_size_d    = ld_size_q;
    ld_signed_d  = ld_signed_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    req_ready    = 1'b0;
    push         = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = req_is_store ? !full : store_queue_empty;
        if (req_valid && req_ready) begin
          if (req_is_store) begin
            push = 1'b1;
          end else begin
            ld_addr_d   = req_addr;
            ld_size_d   = req_size;
            ld_signed_d = req_signed;
            state_d     = LOAD;
          end
        end
      end
      LOAD: begin
        if (mem_fetch_done) begin
          load_data_d  = ext_data;
          load_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pop = !store_queue_empty && mem_write_done;

    if (push) begin
      sq_addr_d[tail_q]  = req_addr;
      sq_data_d[tail_q]  = req_wdata;
      sq_bytes_d[tail_q] = BYTES_W'(1) << eff_size;
      tail_d             = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ld_addr_q    <= '0;
      ld_size_q    <= '0;
      ld_signed_q  <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      for (int i = 0; i < STORE_QUEUE_DEPTH; i++) begin
        sq_addr_q[i]  <= '0;
        sq_data_q[i]  <= '0;
        sq_bytes_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      ld_addr_q    <= ld_addr_d;
      ld_size_q    <= ld_size_d;
      ld_signed_q  <= ld_signed_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      for (int i = 0; i < STORE_QUEUE_DEPTH; i++) begin
        sq_addr_q[i]  <= sq_addr_d[i];
        sq_data_q[i]  <= sq_data_d[i];
        sq_bytes_q[i] <= sq_bytes_d[i];
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; inputs change on the
// falling edge, outputs are checked away from the rising edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        load_valid;
  logic [31:0] load_data;
  logic        store_queue_empty;
  logic [31:0] mem_fetch_addr;
  logic [31:0] mem_fetched_data;
  logic        mem_fetch_done;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_bytes_to_write;
  logic        mem_write_activate;
  logic        mem_write_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_is_store       (req_is_store),
    .req_size           (req_size),
    .req_signed         (req_signed),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .load_valid         (load_valid),
    .load_data          (load_data),
    .store_queue_empty  (store_queue_empty),
    .mem_fetch_addr     (mem_fetch_addr),
    .mem_fetched_data   (mem_fetched_data),
    .mem_fetch_done     (mem_fetch_done),
    .mem_write_addr     (mem_write_addr),
    .mem_write_data     (mem_write_data),
    .mem_bytes_to_write (mem_bytes_to_write),
    .mem_write_activate (mem_write_activate),
    .mem_write_done     (mem_write_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic st, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d);
    req_valid    = v;
    req_is_store = st;
    req_size     = sz;
    req_signed   = sg;
    req_addr     = a;
    req_wdata    = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    mem_fetched_data = 32'h0;
    mem_fetch_done   = 1'b0;
    mem_write_done   = 1'b0;
    repeat (2) @(posedge clk);
    nxt();
    rst = 1'b0;

    // reset state
    chk("rst_empty",     32'(store_queue_empty),  32'd1);
    chk("rst_activate",  32'(mem_write_activate), 32'd0);
    chk("rst_lvalid",    32'(load_valid),         32'd0);
    chk("rst_ldata",     load_data,               32'h0);
    chk("rst_fetch",     mem_fetch_addr,          32'h0);
    chk("rst_waddr",     mem_write_addr,          32'h0);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0); #1;
    chk("rst_ready_st",  32'(req_ready), 32'd1);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0); #1;
    chk("rst_ready_ld",  32'(req_ready), 32'd1);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    nxt();

    // word store
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF); #1;
    chk("ws_ready", 32'(req_ready), 32'd1);
    nxt();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    chk("ws_act",   32'(mem_write_activate), 32'd1);
    chk("ws_addr",  mem_write_addr,          32'h10);
    chk("ws_data",  mem_write_data,          32'hDEADBEEF);
    chk("ws_bytes", 32'(mem_bytes_to_write), 32'd4);
    chk("ws_nempty", 32'(store_queue_empty), 32'd0);
    nxt();
    chk("ws_hold_act",  32'(mem_write_activate), 32'd1);
    chk("ws_hold_addr", mem_write_addr,          32'h10);
    mem_write_done = 1'b1;
    nxt();
    mem_write_done = 1'b0;
    chk("ws_empty_after", 32'(store_queue_empty),  32'd1);
    chk("ws_act_after",   32'(mem_write_activate), 32'd0);

    // queue full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i)); #1;
      chk("qf_ready", 32'(req_ready), 32'd1);
      nxt();
    end
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h110, 32'hA4); #1;
    chk("qf_ready5",  32'(req_ready), 32'd0);
    chk("qf_head0",   mem_write_addr, 32'h100);
    nxt();
    chk("qf_ready5_hold", 32'(req_ready), 32'd0);
    mem_write_done = 1'b1;
    nxt();
    mem_write_done = 1'b0; #1;
    chk("qf_ready_after_pop", 32'(req_ready), 32'd1);
    chk("qf_head1",           mem_write_addr, 32'h104);
    nxt();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk("qf_order_addr", mem_write_addr,          32'h104 + 32'(4 * k));
      chk("qf_order_data", mem_write_data,          32'hA1 + 32'(k));
      chk("qf_order_act",  32'(mem_write_activate), 32'd1);
      mem_write_done = 1'b1;
      nxt();
      mem_write_done = 1'b0;
      nxt();
    end
    chk("qf_drained", 32'(store_queue_empty), 32'd1);

    // store byte then signed byte load
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h20, 32'h80); #1;
    chk("sl_st_ready", 32'(req_ready), 32'd1);
    nxt();
    drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h20, 32'h0); #1;
    chk("sl_ld_blocked", 32'(req_ready),          32'd0);
    chk("sl_bytes",      32'(mem_bytes_to_write), 32'd1);
    mem_write_done = 1'b1;
    nxt();
    mem_write_done = 1'b0; #1;
    chk("sl_ld_ready", 32'(req_ready), 32'd1);
    mem_fetched_data = 32'h00000080;
    mem_fetch_done   = 1'b1;
    nxt();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    chk("sl_fetch_addr", mem_fetch_addr,  32'h20);
    chk("sl_lv_early",   32'(load_valid), 32'd0);
    nxt();
    chk("sl_lv",    32'(load_valid), 32'd1);
    chk("sl_sdata", load_data,       32'hFFFFFF80);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h20, 32'h0); #1;
    chk("sl_b2b_ready", 32'(req_ready), 32'd1);
    nxt();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    chk("sl_lv_low",  32'(load_valid), 32'd0);
    chk("sl_held",    load_data,       32'hFFFFFF80);
    nxt();
    chk("sl_ulv",   32'(load_valid), 32'd1);
    chk("sl_udata", load_data,       32'h00000080);

    // signed half load with a 3-cycle fetch stall
    drive(1'b1, 1'b0, 2'd1, 1'b1, 32'h32, 32'h0);
    mem_fetched_data = 32'h00008001;
    mem_fetch_done   = 1'b0; #1;
    chk("fs_ready", 32'(req_ready), 32'd1);
    nxt();
    drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fs_stall_ready", 32'(req_ready),  32'd0);
      chk("fs_stall_lv",    32'(load_valid), 32'd0);
      nxt();
    end
    chk("fs_last_ready", 32'(req_ready),  32'd0);
    chk("fs_last_lv",    32'(load_valid), 32'd0);
    mem_fetch_done = 1'b1;
    nxt();
    mem_fetch_done = 1'b0;
    chk("fs_lv",    32'(load_valid), 32'd1);
    chk("fs_data",  load_data,       32'hFFFF8001);
    chk("fs_faddr", mem_fetch_addr,  32'h32);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    nxt();

    // reset mid-drain
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h200 + 32'(4 * i), 32'h5 + 32'(i));
      nxt();
    end
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    chk("rd_pre_act", 32'(mem_write_activate), 32'd1);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    chk("rd_act",   32'(mem_write_activate), 32'd0);
    chk("rd_empty", 32'(store_queue_empty),  32'd1);
    chk("rd_waddr", mem_write_addr,          32'h0);
    mem_write_done = 1'b1;
    nxt();
    nxt();
    mem_write_done = 1'b0;
    chk("rd_act_later",   32'(mem_write_activate), 32'd0);
    chk("rd_empty_later", 32'(store_queue_empty),  32'd1);

    // reset abandons an in-flight load
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    mem_fetch_done = 1'b0;
    nxt();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    mem_fetch_done = 1'b1; #1;
    chk("rl_ready", 32'(req_ready), 32'd1);
    nxt();
    chk("rl_lv1", 32'(load_valid), 32'd0);
    nxt();
    chk("rl_lv2", 32'(load_valid), 32'd0);
    mem_fetch_done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
